// File: rtl/dct_pkg.sv
// Shared constants, FSM encoding and the fixed-point row-DCT coefficient table
// (scale 2^7) used by dct_row_mac.
package dct_pkg;

  localparam int N_PTS  = 8;
  localparam int COEF_W = 8;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_WRITE   = 2'd2
  } state_e;

  typedef logic signed [COEF_W-1:0] coef_t;

  // C[k][n] = round(128 * c(k) * cos((2n+1)k*pi/16)), row index k
  localparam coef_t COEF_TBL [N_PTS][N_PTS] = '{
    '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
    '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
    '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
    '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
    '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
    '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
    '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
    '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
  };

  function automatic coef_t coef_lookup(input logic [2:0] k, input logic [2:0] n);
    return COEF_TBL[k][n];
  endfunction

endpackage

// File: rtl/dct_mac_unit.sv
// Shared multiply-accumulate for the row DCT; res_o is the rounded, saturated
// view of the accumulator's next value so the caller can register it directly.
module dct_mac_unit
  import dct_pkg::*;
#(
  parameter int XW     = 9,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 20,
  parameter int WIDTH  = 11,
  parameter int FRAC   = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [XW-1:0]     x_i,
  input  logic signed [COEF_W-1:0] c_i,
  output logic signed [WIDTH-1:0]  res_o
);

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (FRAC - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -SAT_MAX - ACC_W'(1);

  logic signed [XW+COEF_W-1:0] prod_s;
  logic signed [ACC_W-1:0]     acc_q;
  logic signed [ACC_W-1:0]     acc_d;
  logic signed [ACC_W-1:0]     rnd_s;
  logic signed [ACC_W-1:0]     shr_s;

  always_comb begin
    prod_s = x_i * c_i;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod_s);
    end else begin
      acc_d = acc_q;
    end
    // Arithmetic shift after adding half an LSB gives round-half-up.
    rnd_s = acc_d + RND_HALF;
    shr_s = rnd_s >>> FRAC;
    if (shr_s > SAT_MAX) begin
      res_o = SAT_MAX[WIDTH-1:0];
    end else if (shr_s < SAT_MIN) begin
      res_o = SAT_MIN[WIDTH-1:0];
    end else begin
      res_o = shr_s[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dct_row_mac.sv
// Serial 8-point row DCT: loads 8 level-shifted pixels, then computes and
// writes p[0..7] into the partial-product bank through din/wa/enreg.
module dct_row_mac
  import dct_pkg::*;
#(
  parameter int WIDTH  = 11,
  parameter int PIX_W  = 8,
  parameter int COEF_W = dct_pkg::COEF_W,
  parameter int FRAC   = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PIX_W-1:0]        pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic signed [WIDTH-1:0] din,
  output logic [2:0]              wa,
  output logic                    enreg,
  output logic                    busy,
  output logic                    row_done
);

  localparam int XW    = PIX_W + 1;
  localparam int ACC_W = PIX_W + 1 + COEF_W + 3;
  localparam logic signed [XW-1:0] PIX_OFS = {2'b01, {(PIX_W - 1){1'b0}}};

  state_e                  state_q, state_d;
  logic [2:0]              n_q, n_d;
  logic [2:0]              k_q, k_d;
  logic signed [XW-1:0]    xbuf_q [N_PTS];
  logic signed [XW-1:0]    xbuf_d [N_PTS];
  logic signed [WIDTH-1:0] din_q, din_d;
  logic [2:0]              wa_q, wa_d;
  logic                    enreg_q, enreg_d;
  logic                    row_done_q, row_done_d;
  logic                    busy_q, busy_d;
  logic                    mac_en_s, mac_clr_s;
  logic signed [COEF_W-1:0] coef_s;
  logic signed [WIDTH-1:0] mac_res_s;

  assign pix_ready = (state_q == ST_LOAD) && !rst;
  assign coef_s    = COEF_W'(coef_lookup(k_q, n_q));
  assign din       = din_q;
  assign wa        = wa_q;
  assign enreg     = enreg_q;
  assign busy      = busy_q;
  assign row_done  = row_done_q;

  dct_mac_unit #(
    .XW     (XW),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W),
    .WIDTH  (WIDTH),
    .FRAC   (FRAC)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr_s),
    .en_i  (mac_en_s),
    .x_i   (xbuf_q[n_q]),
    .c_i   (coef_s),
    .res_o (mac_res_s)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    xbuf_d     = xbuf_q;
    din_d      = din_q;
    wa_d       = wa_q;
    enreg_d    = 1'b0;
    row_done_d = 1'b0;
    mac_en_s   = 1'b0;
    mac_clr_s  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        mac_clr_s = 1'b1;
        if (pix_valid && pix_ready) begin
          xbuf_d[n_q] = $signed({1'b0, pix_in}) - PIX_OFS;
          n_d         = n_q + 3'd1;
          if (n_q == 3'd7) begin
            state_d = ST_COMPUTE;
            k_d     = 3'd0;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          n_d = n_q;
        end
      end
      ST_COMPUTE: begin
        mac_en_s = 1'b1;
        n_d      = n_q + 3'd1;
        // Last product: the result is taken from the accumulator's next value.
        if (n_q == 3'd7) begin
          state_d    = ST_WRITE;
          enreg_d    = 1'b1;
          wa_d       = k_q;
          din_d      = mac_res_s;
          row_done_d = (k_q == 3'd7);
        end else begin
          state_d = ST_COMPUTE;
        end
      end
      ST_WRITE: begin
        mac_clr_s = 1'b1;
        n_d       = 3'd0;
        if (k_q == 3'd7) begin
          state_d = ST_LOAD;
          k_d     = 3'd0;
        end else begin
          state_d = ST_COMPUTE;
          k_d     = k_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_LOAD;
        n_d     = 3'd0;
        k_d     = 3'd0;
      end
    endcase
    busy_d = (state_d != ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      n_q        <= 3'd0;
      k_q        <= 3'd0;
      xbuf_q     <= '{default: '0};
      din_q      <= '0;
      wa_q       <= 3'd0;
      enreg_q    <= 1'b0;
      row_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      xbuf_q     <= xbuf_d;
      din_q      <= din_d;
      wa_q       <= wa_d;
      enreg_q    <= enreg_d;
      row_done_q <= row_done_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_dct_row_mac.sv
// Randomised bench for dct_row_mac against a cosine-derived reference model,
// with a FRAC=5 instance alongside to exercise saturation.
module tb_dct_row_mac;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] pix_in;
  logic pix_valid;
  logic pix_ready, pix_ready5;
  logic signed [10:0] din, din5;
  logic [2:0] wa, wa5;
  logic enreg, enreg5, busy, busy5, row_done, row_done5;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dct_row_mac dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .din(din), .wa(wa), .enreg(enreg),
    .busy(busy), .row_done(row_done)
  );

  dct_row_mac #(.FRAC(5)) dut_f5 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready5), .din(din5), .wa(wa5), .enreg(enreg5),
    .busy(busy5), .row_done(row_done5)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ref_coef(input int k, input int n);
    real ck;
    real v;
    ck = (k == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
    v  = 128.0 * ck * $cos((2.0 * n + 1.0) * k * 3.14159265358979 / 16.0);
    return int'($floor(v + 0.5));
  endfunction

  function automatic int ref_din(input int pix[8], input int k, input int frac);
    int p;
    int r;
    p = 0;
    for (int n = 0; n < 8; n++) p += (pix[n] - 128) * ref_coef(k, n);
    r = int'($floor((real'(p) + 2.0 ** (frac - 1)) / (2.0 ** frac)));
    if (r > 1023) r = 1023;
    if (r < -1024) r = -1024;
    return r;
  endfunction

  // Feeds one row; t is the cycle count at the negedge preceding acceptance of beat 7.
  task automatic send(input int pix[8], input bit gaps, output int t);
    bit took;
    int t_now;
    t = 0;
    for (int n = 0; n < 8; n++) begin
      pix_valid = 1'b1;
      pix_in    = 8'(pix[n]);
      took      = 1'b0;
      for (int w = 0; w < 200 && !took; w++) begin
        took  = pix_ready;
        t_now = cyc;
        @(posedge clk);
        @(negedge clk);
      end
      if (!took) chk("accept_timeout", 0, 1);
      if (n == 7) t = t_now;
      pix_valid = 1'b0;
      if (gaps && n < 7) begin
        pix_in = 8'($urandom_range(0, 255));
        chk("ready_in_gap", pix_ready, 1);
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic run_row(input int pix[8], input bit gaps, output int t);
    int e7[8];
    int e5[8];
    int nw0;
    int nw1;
    nw0 = 0;
    nw1 = 0;
    for (int k = 0; k < 8; k++) begin
      e7[k] = ref_din(pix, k, 7);
      e5[k] = ref_din(pix, k, 5);
    end
    send(pix, gaps, t);
    chk("compute_busy", busy, 1);
    chk("compute_ready", pix_ready, 0);
    for (int c = 0; c < 150 && (nw0 < 8 || nw1 < 8); c++) begin
      @(negedge clk);
      if (enreg) begin
        if (nw0 < 8) begin
          chk("wa", wa, nw0);
          chk("din", din, e7[nw0]);
          chk("write_cycle", cyc - t, 9 * (nw0 + 1));
          chk("row_done", row_done, (nw0 == 7) ? 1 : 0);
        end
        nw0++;
      end else if (row_done) begin
        chk("row_done_idle", row_done, 0);
      end
      if (enreg5) begin
        if (nw1 < 8) begin
          chk("wa_f5", wa5, nw1);
          chk("din_f5", din5, e5[nw1]);
        end
        nw1++;
      end
      pix_valid = 1'($urandom_range(0, 1));
      pix_in    = 8'($urandom_range(0, 255));
    end
    pix_valid = 1'b0;
    chk("nwrites", nw0, 8);
    chk("nwrites_f5", nw1, 8);
    chk("ready_at_last_write", pix_ready, 0);
    @(negedge clk);
    chk("ready_cycle", cyc - t, 73);
    chk("ready_after_row", pix_ready, 1);
    chk("busy_after_row", busy, 0);
  endtask

  initial begin
    int row[8];
    int t1;
    int t2;
    int cnt;
    bit found;
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_in = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", pix_ready, 0);
    chk("rst_ready_f5", pix_ready5, 0);
    chk("rst_din", din, 0);
    chk("rst_wa", wa, 0);
    chk("rst_enreg", enreg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_row_done", row_done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", pix_ready, 1);

    row = '{128, 128, 128, 128, 128, 128, 128, 128};
    run_row(row, 1'b0, t1);
    row = '{255, 255, 255, 255, 255, 255, 255, 255};
    run_row(row, 1'b0, t1);
    row = '{0, 128, 128, 128, 128, 128, 128, 128};
    run_row(row, 1'b0, t1);
    row = '{255, 0, 255, 0, 255, 0, 255, 0};
    run_row(row, 1'b0, t1);
    row = '{255, 255, 255, 255, 0, 0, 0, 0};
    run_row(row, 1'b0, t1);
    row = '{0, 0, 0, 0, 255, 255, 255, 255};
    run_row(row, 1'b0, t1);

    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < 8; n++) row[n] = $urandom_range(0, 255);
      run_row(row, (r % 2) == 1, t1);
    end

    for (int n = 0; n < 8; n++) row[n] = $urandom_range(0, 255);
    run_row(row, 1'b0, t1);
    for (int n = 0; n < 8; n++) row[n] = $urandom_range(0, 255);
    run_row(row, 1'b0, t2);
    chk("throughput", t2 - t1, 80);

    // Reset on the wa=3 write must discard the rest of the row.
    row = '{255, 255, 255, 255, 255, 255, 255, 255};
    send(row, 1'b0, t1);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (enreg && wa == 3'd3) found = 1'b1;
    end
    chk("wa3_seen", found, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_enreg", enreg, 0);
    chk("midrst_din", din, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", pix_ready, 0);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (enreg || enreg5) cnt++;
    end
    chk("no_enreg_after_rst", cnt, 0);
    run_row(row, 1'b0, t1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
